// File: rtl/sig_dump_ctrl.sv
// End-of-test signature dump controller: snoops control-block writes on the data bus,
// then reads the signature range word by word and streams it out on valid/ready.
module sig_dump_ctrl #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CTRL_BASE = 0,
    parameter int unsigned FLAG_VAL  = 1,
    parameter int unsigned TIMEOUT   = 25000,
    parameter int unsigned MAX_WORDS = 4096,
    localparam int unsigned CNT_W    = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sig_valid,
    input  logic              sig_ready,
    output logic [DATA_W-1:0] sig_data,
    output logic              sig_last,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int unsigned       STRIDE     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] BEGIN_ADDR = ADDR_W'(CTRL_BASE + 2 * STRIDE);
    localparam logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(CTRL_BASE + 3 * STRIDE);
    localparam logic [ADDR_W-1:0] FLAG_ADDR  = ADDR_W'(CTRL_BASE + 4 * STRIDE);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRIDE - 1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(STRIDE);
    localparam logic [ADDR_W:0]   STEP_X     = (ADDR_W + 1)'(STRIDE);
    localparam logic [31:0]       TMO_LAST   = 32'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_RUN, ST_CHECK, ST_READ, ST_WAIT, ST_OUT, ST_DONE, ST_TMO
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] begin_r;
    logic [ADDR_W-1:0] end_r;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       timer;
    logic              start;

    assign start = bus_we && (bus_addr == FLAG_ADDR) && (bus_wdata == DATA_W'(FLAG_VAL));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            begin_r   <= '0;
            end_r     <= '0;
            ptr       <= '0;
            timer     <= '0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            sig_valid <= 1'b0;
            sig_data  <= '0;
            sig_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            word_cnt  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    timer <= timer + 32'd1;
                    if (bus_we && bus_addr == BEGIN_ADDR) begin_r <= ADDR_W'(bus_wdata) & ALIGN_MASK;
                    if (bus_we && bus_addr == END_ADDR)   end_r   <= ADDR_W'(bus_wdata) & ALIGN_MASK;
                    // a start request in the expiry cycle takes priority over the timeout
                    if (start) begin
                        state <= ST_CHECK;
                        busy  <= 1'b1;
                    end else if (TIMEOUT != 0 && timer == TMO_LAST) begin
                        state   <= ST_TMO;
                        timeout <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    ptr <= begin_r;
                    if (begin_r >= end_r) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state    <= ST_READ;
                        mem_re   <= 1'b1;
                        mem_addr <= begin_r;
                    end
                end
                ST_READ: begin
                    mem_re <= 1'b0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    sig_data  <= mem_rdata;
                    // widened compare so a range ending at the top of memory cannot wrap
                    sig_last  <= (({1'b0, ptr} + STEP_X) >= {1'b0, end_r}) ||
                                 ((word_cnt + CNT_ONE) == CNT_MAX);
                    sig_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (sig_ready) begin
                        sig_valid <= 1'b0;
                        word_cnt  <= word_cnt + CNT_ONE;
                        ptr       <= ptr + STEP;
                        if (sig_last) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= ST_READ;
                            mem_re   <= 1'b1;
                            mem_addr <= ptr + STEP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
